// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the carry-select slice geometry used by the trial subtractor.
package seq_restoring_divider_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   localparam int SLICE_W = 4;

   // Operand width must split evenly into carry-select slices.
   function automatic bit width_ok(input int w);
      return (w > 0) && ((w % SLICE_W) == 0);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_csa_sub.sv
// WIDTH-bit subtractor A - B = A + ~B + 1 built from 4-bit carry-select slices.
// carry_o = 1 means no borrow (A >= B).
module csa_sub_nbit
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] d_o,
   output logic             carry_o
);

   localparam int NSL = WIDTH / SLICE_W;

   logic [WIDTH-1:0] nb;
   logic [NSL:0]     c;

   assign nb   = ~b_i;
   assign c[0] = 1'b1;

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("csa_sub_nbit: WIDTH must be a positive multiple of 4");
      end

      // Each slice precomputes both carry-in cases; the incoming carry only selects.
      for (genvar s = 0; s < NSL; s++) begin : g_slice
         logic [SLICE_W:0] sum0;
         logic [SLICE_W:0] sum1;

         assign sum0 = {1'b0, a_i[s*SLICE_W +: SLICE_W]} + {1'b0, nb[s*SLICE_W +: SLICE_W]};
         assign sum1 = {1'b0, a_i[s*SLICE_W +: SLICE_W]} + {1'b0, nb[s*SLICE_W +: SLICE_W]}
                       + {{SLICE_W{1'b0}}, 1'b1};

         assign d_o[s*SLICE_W +: SLICE_W] = c[s] ? sum1[SLICE_W-1:0] : sum0[SLICE_W-1:0];
         assign c[s+1]                    = c[s] ? sum1[SLICE_W]     : sum0[SLICE_W];
      end
   endgenerate

   assign carry_o = c[NSL];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// START is taken in IDLE or DONE; DONE pulses when Q/R/DIV_BY_ZERO are valid.
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             START,
   input  logic [WIDTH-1:0] DIVIDEND,
   input  logic [WIDTH-1:0] DIVISOR,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             DIV_BY_ZERO,
   output div_state_e       STATE_DBG
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   p;
   logic [WIDTH-1:0] diff;
   logic             carry;
   logic             ok;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] dvd_step;

   // Shift the next dividend bit into the partial remainder and try the subtract.
   assign p = {rem_q, dvd_q[WIDTH-1]};

   csa_sub_nbit #(.WIDTH(WIDTH)) u_sub (
      .a_i     (p[WIDTH-1:0]),
      .b_i     (dvs_q),
      .d_o     (diff),
      .carry_o (carry)
   );

   assign ok       = p[WIDTH] | carry;
   assign rem_step = ok ? diff : p[WIDTH-1:0];
   assign dvd_step = {dvd_q[WIDTH-2:0], ok};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      res_d   = res_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (START) begin
               if (DIVISOR != '0) begin
                  state_d = S_RUN;
                  dvd_d   = DIVIDEND;
                  dvs_d   = DIVISOR;
                  rem_d   = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = S_DONE;
                  quo_d   = '1;
                  res_d   = DIVIDEND;
                  dbz_d   = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            rem_d = rem_step;
            dvd_d = dvd_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
               quo_d   = dvd_step;
               res_d   = rem_step;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
         dbz_q   <= dbz_d;
      end
   end

   assign BUSY        = (state_q == S_RUN);
   assign DONE        = (state_q == S_DONE);
   assign Q           = quo_q;
   assign R           = res_q;
   assign DIV_BY_ZERO = dbz_q;
   assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8) against a plain
// arithmetic reference of unsigned division.
module tb_seq_restoring_divider;
   import seq_restoring_divider_pkg::*;

   localparam int W = 8;

   logic         CLK;
   logic         RSTn;
   logic         START;
   logic [W-1:0] DIVIDEND;
   logic [W-1:0] DIVISOR;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] Q;
   logic [W-1:0] R;
   logic         DIV_BY_ZERO;
   div_state_e   STATE_DBG;

   int n_checks = 0;
   int n_fail   = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .START       (START),
      .DIVIDEND    (DIVIDEND),
      .DIVISOR     (DIVISOR),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .Q           (Q),
      .R           (R),
      .DIV_BY_ZERO (DIV_BY_ZERO),
      .STATE_DBG   (STATE_DBG)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // reference model
   function automatic logic [W-1:0] ref_q(input logic [W-1:0] n, input logic [W-1:0] d);
      return (d == 0) ? {W{1'b1}} : W'(int'(n) / int'(d));
   endfunction

   function automatic logic [W-1:0] ref_r(input logic [W-1:0] n, input logic [W-1:0] d);
      return (d == 0) ? n : W'(int'(n) % int'(d));
   endfunction

   // drivers: inputs change 1ns after a rising edge, outputs sampled there too
   task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] d);
      START    = 1'b1;
      DIVIDEND = n;
      DIVISOR  = d;
      step();
      START    = 1'b0;
   endtask

   // Counts edges after the accepting edge until DONE is seen.
   task automatic wait_done(output int cycles, output int busy_cycles, output bit timeout);
      cycles      = 0;
      busy_cycles = 0;
      timeout     = 1'b0;
      while (!DONE) begin
         if (BUSY) busy_cycles++;
         if (cycles >= 40) begin
            timeout = 1'b1;
            break;
         end
         step();
         cycles++;
      end
   endtask

   task automatic test_reset();
      RSTn = 1'b0; START = 1'b0; DIVIDEND = '0; DIVISOR = '0;
      repeat (2) step();
      RSTn = 1'b1;
      step();
      n_checks++;
      if ({BUSY, DONE, Q, R, DIV_BY_ZERO} !== '0 || STATE_DBG !== S_IDLE) begin
         n_fail++;
         $display("FAIL reset: busy=%b done=%b q=%h r=%h dbz=%b st=%0d, required all 0 / IDLE",
                  BUSY, DONE, Q, R, DIV_BY_ZERO, STATE_DBG);
      end
   endtask

   task automatic test_basic();
      int cyc, bcyc; bit to;
      start_op(8'd100, 8'd7);
      wait_done(cyc, bcyc, to);
      n_checks++;
      if (to || cyc != W || bcyc != W) begin
         n_fail++;
         $display("FAIL basic_latency: done after %0d, busy %0d, timeout %b; required %0d/%0d", cyc, bcyc, to, W, W);
      end
      n_checks++;
      if (Q !== 8'd14 || R !== 8'd2 || DIV_BY_ZERO !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: q=%0d r=%0d dbz=%b, required q=14 r=2 dbz=0", Q, R, DIV_BY_ZERO);
      end
      step();
      n_checks++;
      if (DONE !== 1'b0 || STATE_DBG !== S_IDLE || Q !== 8'd14 || R !== 8'd2) begin
         n_fail++;
         $display("FAIL basic_hold: done=%b st=%0d q=%0d r=%0d, required done=0 IDLE q=14 r=2", DONE, STATE_DBG, Q, R);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcyc; bit to;
      start_op(8'd255, 8'd1);
      wait_done(cyc, bcyc, to);
      n_checks++;
      if (to || Q !== 8'd255 || R !== 8'd0) begin
         n_fail++;
         $display("FAIL b2b_first: q=%0d r=%0d timeout=%b, required q=255 r=0", Q, R, to);
      end
      start_op(8'd3, 8'd200);
      n_checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b1 || Q !== 8'd255 || R !== 8'd0) begin
         n_fail++;
         $display("FAIL b2b_accept: done=%b busy=%b q=%0d r=%0d, required done=0 busy=1 q=255 r=0", DONE, BUSY, Q, R);
      end
      wait_done(cyc, bcyc, to);
      n_checks++;
      if (to || cyc != W || Q !== 8'd0 || R !== 8'd3) begin
         n_fail++;
         $display("FAIL b2b_second: cycles=%0d q=%0d r=%0d, required cycles=%0d q=0 r=3", cyc, Q, R, W);
      end
      step();
   endtask

   task automatic test_div_zero();
      int cyc, bcyc; bit to;
      start_op(8'd5, 8'd0);
      wait_done(cyc, bcyc, to);
      n_checks++;
      if (to || cyc != 0 || bcyc != 0) begin
         n_fail++;
         $display("FAIL dbz_latency: done after %0d, busy %0d, required 0/0", cyc, bcyc);
      end
      n_checks++;
      if (Q !== 8'hFF || R !== 8'd5 || DIV_BY_ZERO !== 1'b1) begin
         n_fail++;
         $display("FAIL dbz_result: q=%h r=%0d dbz=%b, required q=ff r=5 dbz=1", Q, R, DIV_BY_ZERO);
      end
      step();
      n_checks++;
      if (DONE !== 1'b0 || DIV_BY_ZERO !== 1'b1) begin
         n_fail++;
         $display("FAIL dbz_hold: done=%b dbz=%b, required done=0 dbz=1", DONE, DIV_BY_ZERO);
      end
   endtask

   task automatic test_start_in_run();
      int cyc, bcyc; bit to;
      start_op(8'd100, 8'd7);
      step(); step();
      start_op(8'd9, 8'd3);
      wait_done(cyc, bcyc, to);
      n_checks++;
      if (to || (cyc + 3) != W || Q !== 8'd14 || R !== 8'd2) begin
         n_fail++;
         $display("FAIL start_in_run: cycles=%0d q=%0d r=%0d, required cycles=%0d q=14 r=2", cyc + 3, Q, R, W);
      end
      step();
   endtask

   task automatic test_reset_mid_run();
      int cyc, bcyc; bit to;
      start_op(8'd200, 8'd13);
      repeat (3) step();
      RSTn = 1'b0;
      #1;
      n_checks++;
      if ({BUSY, DONE, Q, R, DIV_BY_ZERO} !== '0 || STATE_DBG !== S_IDLE) begin
         n_fail++;
         $display("FAIL reset_mid_run: busy=%b done=%b q=%h r=%h dbz=%b st=%0d, required all 0 / IDLE",
                  BUSY, DONE, Q, R, DIV_BY_ZERO, STATE_DBG);
      end
      step();
      RSTn = 1'b1;
      cyc = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (DONE || BUSY) cyc++;
      end
      n_checks++;
      if (cyc != 0) begin
         n_fail++;
         $display("FAIL reset_no_done: %0d active cycles after abort, required 0", cyc);
      end
      start_op(8'd200, 8'd13);
      wait_done(cyc, bcyc, to);
      n_checks++;
      if (to || cyc != W || Q !== 8'd15 || R !== 8'd5) begin
         n_fail++;
         $display("FAIL reset_rerun: cycles=%0d q=%0d r=%0d, required cycles=%0d q=15 r=5", cyc, Q, R, W);
      end
      step();
   endtask

   // Random operands; each next op starts in the DONE cycle of the previous one.
   task automatic test_random(input int n_ops);
      logic [W-1:0] exp_q[$];
      logic [W-1:0] exp_r[$];
      logic [W-1:0] n, d, eq, er;
      int cyc, bcyc, exp_cyc; bit to;
      for (int i = 0; i < n_ops; i++) begin
         if (i == 0)      begin n = 8'h80; d = 8'hFF; end
         else if (i == 1) begin n = 8'hFF; d = 8'hFF; end
         else begin
            n = W'($urandom_range(0, 255));
            d = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(1, 255));
         end
         exp_q.push_back(ref_q(n, d));
         exp_r.push_back(ref_r(n, d));
         exp_cyc = (d == 0) ? 0 : W;
         start_op(n, d);
         wait_done(cyc, bcyc, to);
         eq = exp_q.pop_front();
         er = exp_r.pop_front();
         n_checks++;
         if (to || cyc != exp_cyc || bcyc != exp_cyc) begin
            n_fail++;
            $display("FAIL rand_latency %0d/%0d: cycles=%0d busy=%0d, required %0d", n, d, cyc, bcyc, exp_cyc);
         end
         n_checks++;
         if (Q !== eq || R !== er || DIV_BY_ZERO !== (d == 0)) begin
            n_fail++;
            $display("FAIL rand_result %0d/%0d: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                     n, d, Q, R, DIV_BY_ZERO, eq, er, d == 0);
         end
         if (d != 0) begin
            n_checks++;
            if ((int'(Q) * int'(d) + int'(R)) != int'(n) || R >= d) begin
               n_fail++;
               $display("FAIL rand_invariant %0d/%0d: q=%0d r=%0d", n, d, Q, R);
            end
         end
         if ($urandom_range(0, 3) == 0) step();
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_start_in_run();
      test_reset_mid_run();
      test_random(2000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
